// File: rtl/rv_pipe_pkg.sv
// Shared pipeline constants and types for the fetch/decode boundary.
package rv_pipe_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned FLUSH_SLOTS_MAX = 4;

  // ADD x0,x0,x0: architecturally inert, so a squashed slot decodes harmlessly.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0033;
  localparam logic [6:0]  OP_RTYPE  = 7'b0110011;

  typedef enum logic [1:0] {
    ActLoad,
    ActSquash,
    ActHold
  } slot_act_e;

  function automatic logic is_rtype(input logic [31:0] instr);
    return instr[6:0] == OP_RTYPE;
  endfunction

endpackage

// File: rtl/if_id_flush_reg_if.sv
// Fetch-side control/data and decode-side outputs of the IF/ID register.
interface if_id_flush_reg_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);

  logic             Is_Branch_Taken;
  logic             Stall;
  logic [XLEN-1:0]  Instruction_Fetch;
  logic [XLEN-1:0]  PC_Fetch;
  logic [XLEN-1:0]  Instruction_Decode;
  logic [XLEN-1:0]  PC_Decode;
  logic             Valid_Decode;
  logic             Flush_Active;
  logic [CNT_W-1:0] Squash_Count;

  modport master (
    output Is_Branch_Taken,
    output Stall,
    output Instruction_Fetch,
    output PC_Fetch,
    input  Instruction_Decode,
    input  PC_Decode,
    input  Valid_Decode,
    input  Flush_Active,
    input  Squash_Count
  );

  modport slave (
    input  Is_Branch_Taken,
    input  Stall,
    input  Instruction_Fetch,
    input  PC_Fetch,
    output Instruction_Decode,
    output PC_Decode,
    output Valid_Decode,
    output Flush_Active,
    output Squash_Count
  );

endinterface

// File: rtl/squash_ctr.sv
// Tracks remaining squash slots after a taken branch and a saturating squash tally.
module squash_ctr
  import rv_pipe_pkg::*;
#(
  parameter int unsigned FLUSH_SLOTS = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_branch,
  output logic             o_squash,
  output logic             o_flush_active,
  output logic [CNT_W-1:0] o_squash_count
);

  localparam int unsigned FCW = $clog2(FLUSH_SLOTS + 1);
  localparam logic [FCW-1:0]   Reload  = FCW'(FLUSH_SLOTS - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  if (FLUSH_SLOTS < 1 || FLUSH_SLOTS > FLUSH_SLOTS_MAX) begin : g_bad_slots
    $error("squash_ctr: FLUSH_SLOTS out of range 1..%0d", FLUSH_SLOTS_MAX);
  end

  logic [FCW-1:0]   r_flush_cnt;
  logic [FCW-1:0]   w_flush_cnt_d;
  logic [CNT_W-1:0] r_squash_count;
  logic [CNT_W-1:0] w_squash_count_d;
  logic             w_pending;

  assign w_pending = (r_flush_cnt != '0);
  assign o_squash  = i_branch | w_pending;

  always_comb begin
    w_flush_cnt_d    = r_flush_cnt;
    w_squash_count_d = r_squash_count;
    // A new branch restarts the window rather than extending it.
    if (i_branch) begin
      w_flush_cnt_d = Reload;
    end else if (w_pending) begin
      w_flush_cnt_d = r_flush_cnt - FCW'(1);
    end
    if (o_squash && (r_squash_count != CntMax)) begin
      w_squash_count_d = r_squash_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt    <= '0;
      r_squash_count <= '0;
    end else begin
      r_flush_cnt    <= w_flush_cnt_d;
      r_squash_count <= w_squash_count_d;
    end
  end

  assign o_flush_active = w_pending;
  assign o_squash_count = r_squash_count;

endmodule

// File: rtl/if_id_flush_reg.sv
// IF/ID pipeline register: squashes slots after taken branches, holds on decode stall.
module if_id_flush_reg
  import rv_pipe_pkg::*;
#(
  parameter int unsigned     XLEN        = rv_pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR   = rv_pipe_pkg::NOP_INSTR,
  parameter int unsigned     FLUSH_SLOTS = 1,
  parameter int unsigned     CNT_W       = 16
) (
  input logic               clk,
  input logic               rst_n,
  if_id_flush_reg_if.slave  bus
);

  logic            w_squash;
  slot_act_e       w_act;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;

  squash_ctr #(
    .FLUSH_SLOTS (FLUSH_SLOTS),
    .CNT_W       (CNT_W)
  ) u_squash_ctr (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_branch       (bus.Is_Branch_Taken),
    .o_squash       (w_squash),
    .o_flush_active (bus.Flush_Active),
    .o_squash_count (bus.Squash_Count)
  );

  // Squash beats stall: a killed slot carries nothing worth holding.
  always_comb begin
    w_act = ActLoad;
    if (w_squash) begin
      w_act = ActSquash;
    end else if (bus.Stall) begin
      w_act = ActHold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else begin
      unique case (w_act)
        ActSquash: begin
          r_instr <= NOP_INSTR;
          r_pc    <= bus.PC_Fetch;
          r_valid <= 1'b0;
        end
        ActLoad: begin
          r_instr <= bus.Instruction_Fetch;
          r_pc    <= bus.PC_Fetch;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Instruction_Decode = r_instr;
  assign bus.PC_Decode          = r_pc;
  assign bus.Valid_Decode       = r_valid;

endmodule

// File: tb/tb_if_id_flush_reg.sv
// Randomised plus directed bench for three IF/ID register configurations.
module tb_if_id_flush_reg;

  localparam logic [31:0] NOP = 32'h0000_0033;

  logic clk;
  logic rst_n;

  if_id_flush_reg_if #(.XLEN(32), .CNT_W(4))  if_a ();
  if_id_flush_reg_if #(.XLEN(32), .CNT_W(16)) if_b ();
  if_id_flush_reg_if #(.XLEN(32), .CNT_W(16)) if_c ();

  if_id_flush_reg #(.XLEN(32), .NOP_INSTR(NOP), .FLUSH_SLOTS(3), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  if_id_flush_reg #(.XLEN(32), .NOP_INSTR(NOP), .FLUSH_SLOTS(2), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  if_id_flush_reg #(.XLEN(32), .NOP_INSTR(NOP), .FLUSH_SLOTS(1), .CNT_W(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  logic        in_br, in_st;
  logic [31:0] in_ins, in_pc;

  assign if_a.Is_Branch_Taken = in_br;  assign if_a.Stall = in_st;
  assign if_a.Instruction_Fetch = in_ins; assign if_a.PC_Fetch = in_pc;
  assign if_b.Is_Branch_Taken = in_br;  assign if_b.Stall = in_st;
  assign if_b.Instruction_Fetch = in_ins; assign if_b.PC_Fetch = in_pc;
  assign if_c.Is_Branch_Taken = in_br;  assign if_c.Stall = in_st;
  assign if_c.Instruction_Fetch = in_ins; assign if_c.PC_Fetch = in_pc;

  logic [31:0] obs_ins [3];
  logic [31:0] obs_pc  [3];
  logic        obs_val [3];
  logic        obs_fa  [3];
  logic [31:0] obs_cnt [3];

  assign obs_ins[0] = if_a.Instruction_Decode; assign obs_pc[0] = if_a.PC_Decode;
  assign obs_val[0] = if_a.Valid_Decode;       assign obs_fa[0] = if_a.Flush_Active;
  assign obs_cnt[0] = 32'(if_a.Squash_Count);
  assign obs_ins[1] = if_b.Instruction_Decode; assign obs_pc[1] = if_b.PC_Decode;
  assign obs_val[1] = if_b.Valid_Decode;       assign obs_fa[1] = if_b.Flush_Active;
  assign obs_cnt[1] = 32'(if_b.Squash_Count);
  assign obs_ins[2] = if_c.Instruction_Decode; assign obs_pc[2] = if_c.PC_Decode;
  assign obs_val[2] = if_c.Valid_Decode;       assign obs_fa[2] = if_c.Flush_Active;
  assign obs_cnt[2] = 32'(if_c.Squash_Count);

  // Reference: number of slots still to kill, plus what decode currently shows.
  int unsigned slots   [3] = '{3, 2, 1};
  int unsigned cnt_max [3] = '{15, 65535, 65535};
  logic [31:0] m_ins [3];
  logic [31:0] m_pc  [3];
  logic        m_val [3];
  int unsigned m_left[3];
  int unsigned m_cnt [3];

  int n_checks = 0;
  int n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ins[i] = NOP; m_pc[i] = '0; m_val[i] = 1'b0; m_left[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_edge(input logic br, input logic st, input logic [31:0] ins,
                            input logic [31:0] pc);
    for (int i = 0; i < 3; i++) begin
      logic kill;
      kill = 1'b0;
      if (br) begin
        kill = 1'b1; m_left[i] = slots[i] - 1;
      end else if (m_left[i] > 0) begin
        kill = 1'b1; m_left[i] = m_left[i] - 1;
      end
      if (kill) begin
        m_ins[i] = NOP; m_pc[i] = pc; m_val[i] = 1'b0;
        if (m_cnt[i] < cnt_max[i]) m_cnt[i] = m_cnt[i] + 1;
      end else if (!st) begin
        m_ins[i] = ins; m_pc[i] = pc; m_val[i] = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string phase);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s[%0d] instr", phase, i), obs_ins[i], m_ins[i]);
      check($sformatf("%s[%0d] pc", phase, i), obs_pc[i], m_pc[i]);
      check($sformatf("%s[%0d] valid", phase, i), 32'(obs_val[i]), 32'(m_val[i]));
      check($sformatf("%s[%0d] flush_active", phase, i), 32'(obs_fa[i]),
            32'(m_left[i] != 0));
      check($sformatf("%s[%0d] squash_cnt", phase, i), obs_cnt[i], 32'(m_cnt[i]));
    end
  endtask

  // Inputs change 1ns after an edge and stay stable until the next edge.
  task automatic step(input string phase, input logic br, input logic st,
                      input logic [31:0] ins, input logic [31:0] pc);
    in_br = br; in_st = st; in_ins = ins; in_pc = pc;
    @(posedge clk);
    model_edge(br, st, ins, pc);
    #1;
    check_all(phase);
  endtask

  task automatic rand_step(input string phase, input logic br, input logic st);
    step(phase, br, st, $urandom, $urandom & 32'hffff_fffc);
  endtask

  initial begin
    in_br = 1'b0; in_st = 1'b0; in_ins = '0; in_pc = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("reset");
    rst_n = 1'b1;

    step("normal", 1'b0, 1'b0, 32'h0050_0093, 32'h10);
    check("normal a instr", obs_ins[0], 32'h0050_0093);

    rand_step("branch", 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) rand_step("after_br", 1'b0, 1'b0);
    check("branch a count", obs_cnt[0], 32'd3);
    check("branch b count", obs_cnt[1], 32'd2);
    check("branch c count", obs_cnt[2], 32'd1);

    rand_step("stall_br", 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) rand_step("stall_hold", 1'b0, 1'b1);
    check("stall a valid", 32'(obs_val[0]), 32'd0);
    rand_step("stall_rel", 1'b0, 1'b0);

    rand_step("br_br0", 1'b1, 1'b0);
    rand_step("br_br1", 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) rand_step("br_br_tail", 1'b0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      rand_step("random", ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of a flush window.
    rand_step("pre_rst", 1'b1, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    check("async_rst a instr", obs_ins[0], 32'h33);
    rst_n = 1'b1;
    rand_step("post_rst", 1'b0, 1'b0);

    for (int k = 0; k < 20; k++) rand_step("saturate", 1'b1, ($urandom_range(0, 1) == 1));
    check("saturate a count", obs_cnt[0], 32'hf);
    for (int k = 0; k < 4; k++) rand_step("sat_tail", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
